// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int SA_WIDTH_DEF = 8;

  function automatic logic sa_maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/sa_bit_slice.sv
// One-bit full-adder cell; purely combinational, the carry is registered by the caller.
module sa_bit_slice
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic carry,
  output logic s,
  output logic carry_next
);

  assign s          = a ^ b ^ carry;
  assign carry_next = sa_maj3(a, b, carry);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first, WIDTH+1 cycles from start to done.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  sa_state_t        r_state;
  sa_state_t        w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_carry_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  // Start is only honoured between operations, never mid-shift.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

  sa_bit_slice u_slice (
    .a          (r_a_sr[0]),
    .b          (r_b_sr[0]),
    .carry      (r_carry),
    .s          (w_s),
    .carry_next (w_carry_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == SHIFT);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_result <= '0;
      r_carry  <= c_in;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (r_state == SHIFT) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_result <= {w_s, r_result[WIDTH-1:1]};
      r_carry  <= w_carry_next;
      r_cnt    <= r_cnt + CNT_W'(1);
      // On the MSB cycle r_carry is the carry into the MSB, w_carry_next the carry out.
      if (w_last) begin
        r_cout <= w_carry_next;
`ifdef SERIAL_ADDER_OVF_EN
        r_ovf  <= r_carry ^ w_carry_next;
`endif
      end
    end
  end

  assign sum   = r_result;
  assign c_out = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, corner sequences, random adds vs. arithmetic model.
module tb_serial_adder;

  localparam int W = 8;
  localparam int N = W + 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf_o;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] t;
    t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s  = t[W-1:0];
    co = t[W];
    ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endtask

  logic [W-1:0] cur_ovf_dummy;

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        output int done_at, output int n_done, output int busy_cnt,
                        output logic [W-1:0] s_first, output logic co_first,
                        output logic [W-1:0] s_done, output logic co_done, output logic ov_done,
                        output logic [W-1:0] s_hold);
    done_at = 0; n_done = 0; busy_cnt = 0;
    s_first = '0; co_first = 1'b0; s_done = '0; co_done = 1'b0; ov_done = 1'b0;
    a = xa; b = xb; c_in = xc; start = 1'b1;
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start    = 1'b0;
        s_first  = sum;
        co_first = c_out;
      end
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (done_at == 0) begin
          done_at = i;
          s_done  = sum;
          co_done = c_out;
`ifdef SERIAL_ADDER_OVF_EN
          ov_done = ovf_o;
`endif
        end
      end
    end
    s_hold = sum;
  endtask

  int           d_at, nd, bc, d1, d2, cnt;
  logic [W-1:0] sf, sd, sh, s1, s2, es;
  logic         cf, cd, od, eco, eov;
  logic [W-1:0] ra, rb;
  logic         rc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset_ovf", 32'(ovf_o), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      run_op(tbl[t].a, tbl[t].b, tbl[t].ci, d_at, nd, bc, sf, cf, sd, cd, od, sh);
      chk($sformatf("tbl%0d_done_at", t), 32'(d_at), 32'(W + 1));
      chk($sformatf("tbl%0d_done_cnt", t), 32'(nd), 32'd1);
      chk($sformatf("tbl%0d_busy_cycles", t), 32'(bc), 32'(W));
      chk($sformatf("tbl%0d_sum_cleared", t), 32'(sf), 32'd0);
      chk($sformatf("tbl%0d_cout_cleared", t), 32'(cf), 32'd0);
      chk($sformatf("tbl%0d_sum", t), 32'(sd), 32'(tbl[t].s));
      chk($sformatf("tbl%0d_cout", t), 32'(cd), 32'(tbl[t].co));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("tbl%0d_ovf", t), 32'(od), 32'(tbl[t].ov));
`endif
      chk($sformatf("tbl%0d_sum_held", t), 32'(sh), 32'(tbl[t].s));
    end

    // start held high throughout SHIFT must not restart the operation
    a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
    d_at = 0; sd = '0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (done && d_at == 0) begin
        d_at = i;
        sd   = sum;
      end
      if (i == W) start = 1'b0;
      if (i == W + 2) chk("hold_no_restart_busy", 32'(busy), 32'd0);
    end
    chk("hold_done_at", 32'(d_at), 32'(W + 1));
    chk("hold_sum", 32'(sd), 32'hFF);

    // reset on the 4th SHIFT cycle discards the operation
    a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midrst_ovf", 32'(ovf_o), 32'd0);
`endif
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("midrst_no_done", 32'(cnt), 32'd0);

    // rst and start on the same edge: start dropped
    rst = 1'b1; start = 1'b1; a = 8'h05; b = 8'h06;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_start_busy1", 32'(busy), 32'd0);

    // back-to-back: start held through DONE with new operands
    a = 8'h35; b = 8'h4A; c_in = 1'b0; start = 1'b1;
    d1 = 0; d2 = 0; s1 = '0; s2 = '0;
    for (int i = 1; i <= 2 * W + 6; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) begin
          d1 = i; s1 = sum;
        end else if (d2 == 0) begin
          d2 = i; s2 = sum;
        end
      end
      if (i == W + 1) begin
        a = 8'h01; b = 8'h02;
      end
      if (i == W + 2) begin
        start = 1'b0;
        chk("b2b_busy_restart", 32'(busy), 32'd1);
      end
    end
    chk("b2b_first_done_at", 32'(d1), 32'(W + 1));
    chk("b2b_first_sum", 32'(s1), 32'h7F);
    chk("b2b_second_done_at", 32'(d2), 32'(2 * W + 2));
    chk("b2b_second_sum", 32'(s2), 32'h03);

    // randomized adds against the arithmetic model
    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rc, es, eco, eov);
      run_op(ra, rb, rc, d_at, nd, bc, sf, cf, sd, cd, od, sh);
      chk($sformatf("rnd%0d_done_at", t), 32'(d_at), 32'(W + 1));
      chk($sformatf("rnd%0d_sum a=%0h b=%0h ci=%0d", t, ra, rb, rc), 32'(sd), 32'(es));
      chk($sformatf("rnd%0d_cout", t), 32'(cd), 32'(eco));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("rnd%0d_ovf", t), 32'(od), 32'(eov));
`endif
      chk($sformatf("rnd%0d_sum_held", t), 32'(sh), 32'(es));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
